// File: rtl/axi3_rd_arbiter_if.sv
// axi3_rd_arbiter_if: AXI3 read-address/read-data channel bundle for N lanes (N=1 for a single port)
interface axi3_rd_arbiter_if #(
  parameter int N      = 1,
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
);
  logic [N-1:0][ID_W-1:0]   arid;
  logic [N-1:0][ADDR_W-1:0] araddr;
  logic [N-1:0][3:0]        arlen;
  logic [N-1:0][2:0]        arsize;
  logic [N-1:0][1:0]        arburst;
  logic [N-1:0][1:0]        arlock;
  logic [N-1:0][3:0]        arcache;
  logic [N-1:0][2:0]        arprot;
  logic [N-1:0]             arvalid;
  logic [N-1:0]             arready;
  logic [N-1:0][ID_W-1:0]   rid;
  logic [N-1:0][DATA_W-1:0] rdata;
  logic [N-1:0][1:0]        rresp;
  logic [N-1:0]             rlast;
  logic [N-1:0]             rvalid;
  logic [N-1:0]             rready;
  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );
  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
    output arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/axi3_rd_arbiter.sv
// axi3_rd_arbiter: round-robin N-to-1 AXI3 read arbiter; optional per-master outstanding limit via AXI3_RD_ARB_OUTSTD_LIMIT_EN
module axi3_rd_arbiter #(
  parameter int NUM_MST    = 4,
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int MAX_OUTSTD = 4
) (
  input  logic             aclk,
  input  logic             areset_n,
  axi3_rd_arbiter_if.slave  s,
  axi3_rd_arbiter_if.master m,
  output logic             r_dec_err
);
  localparam int IDX_W = $clog2(NUM_MST);
  localparam logic [IDX_W:0] NUM = (IDX_W+1)'(NUM_MST);
  if (NUM_MST < 2 || NUM_MST > 16 || MAX_OUTSTD < 1) begin : g_bad_param
    $error("axi3_rd_arbiter: parameter out of range");
  end
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state;
  logic [IDX_W-1:0] rr_ptr, win, r_idx;
  logic [IDX_W:0] j;
  logic [NUM_MST-1:0] full, eligible;
  logic any, r_hit;
`ifdef AXI3_RD_ARB_OUTSTD_LIMIT_EN
  localparam int CW = $clog2(MAX_OUTSTD+1);
  logic [NUM_MST-1:0][CW-1:0] cnt;
  // a master at its outstanding ceiling is hidden from arbitration
  always_comb begin
    full = '0;
    for (int i = 0; i < NUM_MST; i++) full[i] = cnt[i] == CW'(MAX_OUTSTD);
  end
  // accept raises, last-beat handshake lowers; both together cancel out
  always_ff @(posedge aclk) begin
    if (!areset_n) cnt <= '0;
    else
      for (int i = 0; i < NUM_MST; i++) begin
        if (s.arready[i] && !(s.rvalid[i] && s.rready[i] && m.rlast[0])) cnt[i] <= cnt[i] + 1'b1;
        else if (!s.arready[i] && s.rvalid[i] && s.rready[i] && m.rlast[0] && cnt[i] != '0) cnt[i] <= cnt[i] - 1'b1;
      end
  end
`else
  assign full = '0;
`endif
  assign eligible = s.arvalid & ~full;
  // pick the first eligible master at or after rr_ptr; the descending scan lets the nearest one win
  always_comb begin
    win = '0;
    any = 1'b0;
    j = '0;
    for (int i = NUM_MST-1; i >= 0; i--) begin
      j = {1'b0, rr_ptr} + (IDX_W+1)'(i);
      j = j >= NUM ? j - NUM : j;
      if (eligible[j[IDX_W-1:0]]) begin
        win = j[IDX_W-1:0];
        any = 1'b1;
      end
    end
  end
  // upstream handshake completes in the same cycle the winner is chosen
  always_comb begin
    s.arready = '0;
    if (state == IDLE && any) s.arready[win] = 1'b1;
  end
  // AR FSM: capture winner payload in IDLE, present it downstream in BUSY until accepted
  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      m.arvalid <= '0;
      m.arid    <= '0;
      m.araddr  <= '0;
      m.arlen   <= '0;
      m.arsize  <= '0;
      m.arburst <= '0;
      m.arlock  <= '0;
      m.arcache <= '0;
      m.arprot  <= '0;
    end else begin
      case (state)
        IDLE: if (any) begin
          state     <= BUSY;
          rr_ptr    <= win == IDX_W'(NUM_MST-1) ? '0 : win + 1'b1;
          m.arvalid <= 1'b1;
          m.arid    <= {win, s.arid[win][ID_WIDTH-1:0]};
          m.araddr  <= s.araddr[win][ADDR_WIDTH-1:0];
          m.arlen   <= s.arlen[win];
          m.arsize  <= s.arsize[win];
          m.arburst <= s.arburst[win];
          m.arlock  <= s.arlock[win];
          m.arcache <= s.arcache[win];
          m.arprot  <= s.arprot[win];
        end
        BUSY: if (m.arready[0]) begin
          state     <= IDLE;
          m.arvalid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign r_idx = m.rid[0][ID_WIDTH+IDX_W-1:ID_WIDTH];
  assign r_hit = {1'b0, r_idx} < NUM;
  assign s.rid   = {NUM_MST{m.rid[0][ID_WIDTH-1:0]}};
  assign s.rdata = {NUM_MST{m.rdata[0][DATA_WIDTH-1:0]}};
  assign s.rresp = {NUM_MST{m.rresp[0]}};
  assign s.rlast = {NUM_MST{m.rlast[0]}};
  // R steering by ID prefix; beats for non-existent masters are sunk
  always_comb begin
    s.rvalid = '0;
    if (r_hit) s.rvalid[r_idx] = m.rvalid[0];
    m.rready = r_hit ? s.rready[r_idx] : 1'b1;
  end
  // sticky decode-error flag, cleared only by reset
  always_ff @(posedge aclk) begin
    if (!areset_n) r_dec_err <= 1'b0;
    else if (m.rvalid[0] && !r_hit) r_dec_err <= 1'b1;
  end
endmodule

// File: tb/tb_axi3_rd_arbiter.sv
// tb_axi3_rd_arbiter: directed self-checking bench for axi3_rd_arbiter (4-master and 3-master instances)
module tb_axi3_rd_arbiter;
  logic aclk = 1'b0;
  logic areset_n = 1'b0;
  logic dec4, dec3;
  int n_chk = 0;
  int n_fail = 0;
  always #5 aclk = ~aclk;
  axi3_rd_arbiter_if #(.N(4), .ID_W(4), .ADDR_W(32), .DATA_W(64)) up4 ();
  axi3_rd_arbiter_if #(.N(1), .ID_W(6), .ADDR_W(32), .DATA_W(64)) dn4 ();
  axi3_rd_arbiter_if #(.N(3), .ID_W(4), .ADDR_W(32), .DATA_W(64)) up3 ();
  axi3_rd_arbiter_if #(.N(1), .ID_W(6), .ADDR_W(32), .DATA_W(64)) dn3 ();
  axi3_rd_arbiter #(.NUM_MST(4), .MAX_OUTSTD(2)) u4 (.aclk(aclk), .areset_n(areset_n), .s(up4), .m(dn4), .r_dec_err(dec4));
  axi3_rd_arbiter #(.NUM_MST(3)) u3 (.aclk(aclk), .areset_n(areset_n), .s(up3), .m(dn3), .r_dec_err(dec3));
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step;
    @(posedge aclk);
    #1;
  endtask
  initial begin
    logic [5:0] e_id;
    up4.arid = '0; up4.araddr = '0; up4.arlen = '0; up4.arsize = '0; up4.arburst = '0;
    up4.arlock = '0; up4.arcache = '0; up4.arprot = '0; up4.arvalid = '0; up4.rready = '0;
    up3.arid = '0; up3.araddr = '0; up3.arlen = '0; up3.arsize = '0; up3.arburst = '0;
    up3.arlock = '0; up3.arcache = '0; up3.arprot = '0; up3.arvalid = '0; up3.rready = '0;
    dn4.arready = '0; dn4.rid = '0; dn4.rdata = '0; dn4.rresp = '0; dn4.rlast = '0; dn4.rvalid = '0;
    dn3.arready = '0; dn3.rid = '0; dn3.rdata = '0; dn3.rresp = '0; dn3.rlast = '0; dn3.rvalid = '0;
    step;
    step;
    areset_n = 1'b1;
    #1;
    check("rst_arvalid", dn4.arvalid, 1'b0);
    check("rst_arready", up4.arready, 4'b0000);
    check("rst_arid", dn4.arid, 6'h00);
    check("rst_dec4", dec4, 1'b0);
    check("rst_dec3", dec3, 1'b0);
    up4.arid[1] = 4'h3;
    up4.araddr[1] = 32'h1000_0040;
    up4.arlen[1] = 4'h7;
    up4.arburst[1] = 2'b01;
    up4.arvalid = 4'b0010;
    #1;
    check("single_arready", up4.arready, 4'b0010);
    step;
    up4.arvalid = 4'b0001;
    #1;
    check("single_araddr", dn4.araddr, 32'h1000_0040);
    check("single_arlen", dn4.arlen, 4'h7);
    check("single_arburst", dn4.arburst, 2'b01);
    for (int c = 0; c < 3; c++) begin
      check("hold_arvalid", dn4.arvalid, 1'b1);
      check("hold_arid", dn4.arid, 6'h13);
      check("hold_arready", up4.arready, 4'b0000);
      step;
    end
    up4.arvalid = 4'b0000;
    dn4.arready = 1'b1;
    step;
    dn4.arready = 1'b0;
    #1;
    check("single_done", dn4.arvalid, 1'b0);
    up4.arid[2] = 4'h5;
    up4.arvalid = 4'b0100;
    #1;
    check("rb_arready", up4.arready, 4'b0100);
    step;
    up4.arvalid = 4'b0000;
    #1;
    check("rb_busy_arid", dn4.arid, 6'h25);
    areset_n = 1'b0;
    step;
    areset_n = 1'b1;
    #1;
    check("rb_arvalid", dn4.arvalid, 1'b0);
    check("rb_arid", dn4.arid, 6'h00);
    for (int i = 0; i < 4; i++) up4.arid[i] = 4'(8 + i);
    up4.arvalid = 4'b1111;
    dn4.arready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("rr_grant", up4.arready, 64'(4'b0001 << (k % 4)));
      step;
      #1;
      e_id = {2'(k % 4), 4'(8 + k % 4)};
      check("rr_arvalid", dn4.arvalid, 1'b1);
      check("rr_arid", dn4.arid, e_id);
      check("rr_busy_arready", up4.arready, 4'b0000);
      step;
    end
    up4.arvalid = 4'b0000;
    dn4.arready = 1'b0;
    step;
    dn4.rvalid = 1'b1;
    dn4.rid = 6'h2A;
    dn4.rdata = 64'hDEAD_BEEF_0123_4567;
    dn4.rresp = 2'b10;
    dn4.rlast = 1'b1;
    up4.rready = 4'b0000;
    #1;
    check("r_rvalid", up4.rvalid, 4'b0100);
    check("r_rready_lo", dn4.rready, 1'b0);
    check("r_rid", up4.rid[2], 4'hA);
    check("r_rdata", up4.rdata[2], 64'hDEAD_BEEF_0123_4567);
    check("r_rresp", up4.rresp[2], 2'b10);
    check("r_rlast", up4.rlast[2], 1'b1);
    up4.rready = 4'b0100;
    #1;
    check("r_rready_hi", dn4.rready, 1'b1);
    up4.rready = 4'b1011;
    #1;
    check("r_rready_other", dn4.rready, 1'b0);
    dn4.rid = 6'h05;
    up4.rready = 4'b0001;
    #1;
    check("r0_rvalid", up4.rvalid, 4'b0001);
    check("r0_rready", dn4.rready, 1'b1);
    check("r0_rid", up4.rid[0], 4'h5);
    dn4.rvalid = 1'b0;
    dn4.rlast = 1'b0;
    up4.rready = 4'b0000;
    #1;
    check("r_idle_rvalid", up4.rvalid, 4'b0000);
    check("r_dec4", dec4, 1'b0);
    step;
    dn3.rvalid = 1'b1;
    dn3.rid = 6'h21;
    up3.rready = 3'b100;
    #1;
    check("r3_rvalid", up3.rvalid, 3'b100);
    check("r3_rready", dn3.rready, 1'b1);
    dn3.rid = 6'h31;
    up3.rready = 3'b000;
    #1;
    check("dec_rready", dn3.rready, 1'b1);
    check("dec_rvalid", up3.rvalid, 3'b000);
    check("dec_pre", dec3, 1'b0);
    step;
    check("dec_set", dec3, 1'b1);
    dn3.rvalid = 1'b0;
    step;
    step;
    check("dec_sticky", dec3, 1'b1);
    areset_n = 1'b0;
    step;
    areset_n = 1'b1;
    #1;
    check("dec_clear", dec3, 1'b0);
`ifdef AXI3_RD_ARB_OUTSTD_LIMIT_EN
    up4.arvalid = 4'b0001;
    dn4.arready = 1'b1;
    #1;
    check("lim_first", up4.arready, 4'b0001);
    step;
    step;
    check("lim_second", up4.arready, 4'b0001);
    step;
    step;
    up4.arvalid = 4'b0011;
    #1;
    check("lim_masked", up4.arready, 4'b0010);
    step;
    step;
    up4.arvalid = 4'b0001;
    #1;
    check("lim_blocked", up4.arready, 4'b0000);
    dn4.rid = 6'h08;
    dn4.rlast = 1'b1;
    dn4.rvalid = 1'b1;
    up4.rready = 4'b0001;
    step;
    dn4.rvalid = 1'b0;
    dn4.rlast = 1'b0;
    up4.rready = 4'b0000;
    #1;
    check("lim_release", up4.arready, 4'b0001);
    up4.arvalid = 4'b0000;
    step;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
